// File: rtl/sram_arbiter.sv
// sram_arbiter: write-priority arbiter and strobe sequencer for the dual-bank asynchronous SRAM.
// Latency: wr_ack WE_CYCLES+2 cycles and rd_valid RD_CYCLES+1 cycles after the request is first seen in IDLE.
// Backpressure: requesters hold req until ack/valid; writes win unless STARVE_LIMIT writes in a row held off a pending read.
module sram_arbiter #(
  parameter int WE_CYCLES    = 2,
  parameter int RD_CYCLES    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        sram_clk,
  input  logic        sram_reset_n,
  input  logic        wr_req,
  input  logic [17:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [17:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [17:0] SRADDR,
  output logic        SROE_N,
  output logic        SRWE_N,
  output logic        SRCE1_N,
  output logic        SRCE2_N,
  inout  wire  [15:0] SRDATA1,
  inout  wire  [15:0] SRDATA2
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_ACCESS,
    RD_END
  } state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [7:0] WE_LAST    = 8'(WE_CYCLES - 1);
  localparam logic [7:0] RD_LAST    = 8'(RD_CYCLES - 1);

  state_t      state;
  logic [7:0]  phaseCnt;   // remaining cycles in WR_PULSE / RD_ACCESS
  logic [7:0]  streak;     // writes granted in a row while a read waited
  logic [31:0] wrWord;     // write word latched at grant
  logic        driveBus;   // block owns the data pins
  logic        ceN;
  logic        oeN;
  logic        weN;
  logic        grantWr;

  // A pending read only blocks the write once it has been passed over STARVE_LIMIT times.
  assign grantWr = wr_req && !(rd_req && (streak == STARVE_MAX));

  // Both chip enables come from one register so the banks can never disagree.
  assign SRCE1_N = ceN;
  assign SRCE2_N = ceN;
  assign SROE_N  = oeN;
  assign SRWE_N  = weN;

  // Pins are driven only from the registered enable, which reset clears asynchronously.
  assign SRDATA1 = driveBus ? wrWord[15:0]  : 16'bz;
  assign SRDATA2 = driveBus ? wrWord[31:16] : 16'bz;

  // Arbitration, cycle sequencing and every registered strobe/handshake output.
  always_ff @(posedge sram_clk or negedge sram_reset_n) begin
    if (!sram_reset_n) begin
      state    <= IDLE;
      phaseCnt <= '0;
      streak   <= '0;
      wrWord   <= '0;
      driveBus <= 1'b0;
      ceN      <= 1'b1;
      oeN      <= 1'b1;
      weN      <= 1'b1;
      SRADDR   <= '0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grantWr) begin
            state    <= WR_SETUP;
            busy     <= 1'b1;
            SRADDR   <= wr_addr;
            wrWord   <= wr_data;
            ceN      <= 1'b0;
            driveBus <= 1'b1;
            if (!rd_req) begin
              streak <= '0;
            end else if (streak != STARVE_MAX) begin
              streak <= streak + 8'd1;
            end
          end else if (rd_req) begin
            state    <= RD_ACCESS;
            busy     <= 1'b1;
            SRADDR   <= rd_addr;
            ceN      <= 1'b0;
            oeN      <= 1'b0;
            phaseCnt <= RD_LAST;
            streak   <= '0;
          end else begin
            streak <= '0;
          end
        end
        WR_SETUP: begin
          state    <= WR_PULSE;
          weN      <= 1'b0;
          phaseCnt <= WE_LAST;
        end
        WR_PULSE: begin
          if (phaseCnt == 8'd0) begin
            state  <= WR_HOLD;
            weN    <= 1'b1;
            wr_ack <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt - 8'd1;
          end
        end
        WR_HOLD: begin
          state    <= IDLE;
          ceN      <= 1'b1;
          driveBus <= 1'b0;
          busy     <= 1'b0;
        end
        RD_ACCESS: begin
          if (phaseCnt == 8'd0) begin
            state    <= RD_END;
            rd_data  <= {SRDATA2, SRDATA1};
            rd_valid <= 1'b1;
            oeN      <= 1'b1;
            ceN      <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt - 8'd1;
          end
        end
        RD_END: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives sram_arbiter with directed and random traffic against a simple SRAM model.
// Expected timing and data come from the documented cycle counts and a write-history reference memory.
// A second instance with STARVE_LIMIT=1 checks the alternating starvation pattern.
module tb_sram_arbiter;

  localparam int WE  = 2;
  localparam int RD  = 2;
  localparam int LIM = 4;

  logic sram_clk = 1'b0;
  logic sram_reset_n;
  always #5 sram_clk = ~sram_clk;

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  always @(posedge sram_clk) cycle <= cycle + 1;

  // instance A (default parameters)
  logic        wrReq, wrAck, rdReq, rdValid, busy;
  logic [17:0] wrAddr, rdAddr, srAddr;
  logic [31:0] wrData, rdData;
  logic        srOeN, srWeN, srCe1N, srCe2N;
  wire  [15:0] srData1, srData2;

  sram_arbiter #(.WE_CYCLES(WE), .RD_CYCLES(RD), .STARVE_LIMIT(LIM)) dutA (
    .sram_clk(sram_clk), .sram_reset_n(sram_reset_n),
    .wr_req(wrReq), .wr_addr(wrAddr), .wr_data(wrData), .wr_ack(wrAck),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_data(rdData), .rd_valid(rdValid),
    .busy(busy), .SRADDR(srAddr), .SROE_N(srOeN), .SRWE_N(srWeN),
    .SRCE1_N(srCe1N), .SRCE2_N(srCe2N), .SRDATA1(srData1), .SRDATA2(srData2)
  );

  // instance B (starvation limit of one)
  logic        wrReqB, wrAckB, rdReqB, rdValidB, busyB;
  logic [17:0] wrAddrB, rdAddrB, srAddrB;
  logic [31:0] wrDataB, rdDataB;
  logic        srOeNB, srWeNB, srCe1NB, srCe2NB;
  wire  [15:0] srData1B, srData2B;

  sram_arbiter #(.WE_CYCLES(WE), .RD_CYCLES(RD), .STARVE_LIMIT(1)) dutB (
    .sram_clk(sram_clk), .sram_reset_n(sram_reset_n),
    .wr_req(wrReqB), .wr_addr(wrAddrB), .wr_data(wrDataB), .wr_ack(wrAckB),
    .rd_req(rdReqB), .rd_addr(rdAddrB), .rd_data(rdDataB), .rd_valid(rdValidB),
    .busy(busyB), .SRADDR(srAddrB), .SROE_N(srOeNB), .SRWE_N(srWeNB),
    .SRCE1_N(srCe1NB), .SRCE2_N(srCe2NB), .SRDATA1(srData1B), .SRDATA2(srData2B)
  );

  assign srData1B = (!srCe1NB && !srOeNB) ? 16'hF00D : 16'bz;
  assign srData2B = (!srCe1NB && !srOeNB) ? 16'h0BAD : 16'bz;

  // Power-on SRAM contents: a fixed pattern, with the top word holding a known marker.
  function automatic logic [31:0] preload(input logic [17:0] a);
    return (a[11:0] == 12'hFFF) ? 32'h1234ABCD : (32'hC0DE0000 | {14'd0, a});
  endfunction

  // An undriven bus reads as z in a four-state simulator and as 0 in a two-state one.
  function automatic bit released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // SRAM model for instance A: 4K words aliased on the low address bits.
  logic [31:0] memA [0:4095];
  logic        memInit = 1'b0;
  wire  [31:0] memWordA = memA[srAddr[11:0]];
  assign srData1 = (!srCe1N && !srOeN) ? memWordA[15:0]  : 16'bz;
  assign srData2 = (!srCe1N && !srOeN) ? memWordA[31:16] : 16'bz;

  always @(posedge sram_clk) begin
    if (!memInit) begin
      for (int i = 0; i < 4096; i++) memA[i] <= preload(18'(i));
      memInit <= 1'b1;
    end else if (!srCe1N && !srWeN) begin
      memA[srAddr[11:0]] <= {srData2, srData1};
    end
  end

  // Reference memory: the last word written to each address.
  logic [31:0] refMem [int];

  // Bus-rule monitor on instance A.
  int violations = 0;
  always @(negedge sram_clk) begin
    if (sram_reset_n) begin
      violations <= violations
        + int'(!srWeN && !srOeN)
        + int'(srCe1N !== srCe2N)
        + int'(!srOeN && ({srData2, srData1} !== memWordA))
        + int'(srCe1N && !(released(srData1) && released(srData2)));
    end
  end

  task automatic doWrite(input logic [17:0] a, input logic [31:0] d, output int ackCyc);
    bit done = 1'b0;
    ackCyc = -1;
    wrAddr = a; wrData = d; wrReq = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge sram_clk);
      if (wrAck) begin done = 1'b1; ackCyc = cycle; end
      @(posedge sram_clk); #1;
      if (done) break;
    end
    wrReq = 1'b0;
    refMem[a] = d;
    checks++;
    if (!done) begin fails++; $display("FAIL write_timeout: addr %h got no wr_ack, required one within 40 cycles", a); end
  endtask

  task automatic doRead(input logic [17:0] a, output logic [31:0] d, output int vldCyc);
    bit done = 1'b0;
    vldCyc = -1; d = '0;
    rdAddr = a; rdReq = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge sram_clk);
      if (rdValid) begin done = 1'b1; vldCyc = cycle; d = rdData; end
      @(posedge sram_clk); #1;
      if (done) break;
    end
    rdReq = 1'b0;
    checks++;
    if (!done) begin fails++; $display("FAIL read_timeout: addr %h got no rd_valid, required one within 40 cycles", a); end
  endtask

  function automatic logic [31:0] expectRead(input logic [17:0] a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : preload(a);
  endfunction

  task automatic test_reset();
    sram_reset_n = 1'b0;
    wrReq = 0; rdReq = 0; wrAddr = 0; rdAddr = 0; wrData = 0;
    wrReqB = 0; rdReqB = 0; wrAddrB = 0; rdAddrB = 0; wrDataB = 0;
    repeat (3) @(posedge sram_clk);
    #1;
    checks++; if (wrAck !== 1'b0) begin fails++; $display("FAIL reset_wr_ack: got %b required 0", wrAck); end
    checks++; if (rdValid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b required 0", rdValid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (rdData !== 32'h0) begin fails++; $display("FAIL reset_rd_data: got %h required 0", rdData); end
    checks++; if (srAddr !== 18'h0) begin fails++; $display("FAIL reset_sraddr: got %h required 0", srAddr); end
    checks++; if ({srOeN, srWeN, srCe1N, srCe2N} !== 4'b1111) begin fails++; $display("FAIL reset_strobes: got %b required 1111", {srOeN, srWeN, srCe1N, srCe2N}); end
    checks++; if (!(released(srData1) && released(srData2))) begin fails++; $display("FAIL reset_bus: got %h_%h required released", srData2, srData1); end
    sram_reset_n = 1'b1;
    repeat (2) @(posedge sram_clk);
    #1;
  endtask

  task automatic test_single_write();
    int weLow = 0, ceLow = 0, firstCe = -1, lastCe = -1, firstWe = -1, ackAt = -1, ackCnt = 0, dataBad = 0;
    wrAddr = 18'h00012; wrData = 32'hA5A55A5A; wrReq = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge sram_clk);
      if (!srWeN) begin weLow++; if (firstWe < 0) firstWe = c; end
      if (!srCe1N) begin
        ceLow++;
        if (firstCe < 0) firstCe = c;
        lastCe = c;
        if ({srData2, srData1} !== 32'hA5A55A5A || srAddr !== 18'h00012) dataBad++;
      end
      if (wrAck) begin ackCnt++; ackAt = c; end
      @(posedge sram_clk); #1;
      if (ackCnt != 0) wrReq = 1'b0;
    end
    refMem[18'h12] = 32'hA5A55A5A;
    checks++; if (weLow != WE) begin fails++; $display("FAIL wr_we_width: got %0d cycles required %0d", weLow, WE); end
    checks++; if (firstWe != 2) begin fails++; $display("FAIL wr_we_start: got cycle %0d required 2", firstWe); end
    checks++; if (firstCe != 1) begin fails++; $display("FAIL wr_ce_start: got cycle %0d required 1", firstCe); end
    checks++; if (lastCe != WE + 2 || ceLow != WE + 2) begin fails++; $display("FAIL wr_ce_window: got last %0d count %0d required %0d", lastCe, ceLow, WE + 2); end
    checks++; if (dataBad != 0) begin fails++; $display("FAIL wr_bus_data: got %0d bad cycles required 0", dataBad); end
    checks++; if (ackCnt != 1) begin fails++; $display("FAIL wr_ack_count: got %0d required 1", ackCnt); end
    checks++; if (ackAt != WE + 2) begin fails++; $display("FAIL wr_ack_latency: got %0d required %0d", ackAt, WE + 2); end
  endtask

  task automatic test_single_read();
    int oeLow = 0, firstOe = -1, vldAt = -1, vldCnt = 0, drv = 0;
    logic [31:0] got = '0;
    rdAddr = 18'h3FFFF; rdReq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge sram_clk);
      if (!srOeN) begin oeLow++; if (firstOe < 0) firstOe = c; end
      else if (!(released(srData1) && released(srData2))) drv++;
      if (rdValid) begin vldCnt++; vldAt = c; got = rdData; end
      @(posedge sram_clk); #1;
      if (vldCnt != 0) rdReq = 1'b0;
    end
    checks++; if (oeLow != RD) begin fails++; $display("FAIL rd_oe_width: got %0d required %0d", oeLow, RD); end
    checks++; if (firstOe != 1) begin fails++; $display("FAIL rd_oe_start: got cycle %0d required 1", firstOe); end
    checks++; if (drv != 0) begin fails++; $display("FAIL rd_bus_driven: got %0d cycles required 0", drv); end
    checks++; if (vldCnt != 1) begin fails++; $display("FAIL rd_valid_count: got %0d required 1", vldCnt); end
    checks++; if (vldAt != RD + 1) begin fails++; $display("FAIL rd_valid_latency: got %0d required %0d", vldAt, RD + 1); end
    checks++; if (got !== 32'h1234ABCD) begin fails++; $display("FAIL rd_data: got %h required 1234abcd", got); end
    repeat (3) @(posedge sram_clk);
    #1;
    checks++; if (rdData !== 32'h1234ABCD) begin fails++; $display("FAIL rd_data_hold: got %h required 1234abcd", rdData); end
  endtask

  task automatic test_simultaneous();
    int ackAt = -1, vldAt = -1;
    logic [31:0] d = $urandom | 32'h00010001;
    logic [31:0] got = '0;
    wrAddr = 18'h00020; wrData = d; rdAddr = 18'h00020;
    wrReq = 1'b1; rdReq = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge sram_clk);
      if (wrAck && ackAt < 0) ackAt = c;
      if (rdValid && vldAt < 0) begin vldAt = c; got = rdData; end
      @(posedge sram_clk); #1;
      if (ackAt >= 0) wrReq = 1'b0;
      if (vldAt >= 0) rdReq = 1'b0;
    end
    refMem[18'h20] = d;
    checks++; if (ackAt != WE + 2) begin fails++; $display("FAIL simul_write_first: ack at %0d required %0d", ackAt, WE + 2); end
    checks++; if (vldAt != WE + 3 + RD + 1) begin fails++; $display("FAIL simul_read_next: valid at %0d required %0d", vldAt, WE + 3 + RD + 1); end
    checks++; if (got !== d) begin fails++; $display("FAIL simul_read_data: got %h required %h", got, d); end
  endtask

  task automatic test_starvation();
    byte ev [$];
    int nw = 0;
    wrAddr = 18'h40; wrData = $urandom | 32'h00010001;
    rdAddr = 18'h41;
    wrReq = 1'b1; rdReq = 1'b1;
    for (int c = 0; c < 200 && ev.size() < 10; c++) begin
      @(negedge sram_clk);
      if (wrAck) begin ev.push_back("W"); refMem[int'(wrAddr)] = wrData; end
      if (rdValid) ev.push_back("R");
      @(posedge sram_clk); #1;
      if (wrAck) begin nw++; wrAddr = 18'h40 + 18'(nw); wrData = $urandom | 32'h00010001; end
    end
    wrReq = 1'b0; rdReq = 1'b0;
    checks++; if (ev.size() != 10) begin fails++; $display("FAIL starve_events: got %0d events required 10", ev.size()); end
    for (int k = 0; k < ev.size(); k++) begin
      byte want = ((k % (LIM + 1)) == LIM) ? "R" : "W";
      checks++; if (ev[k] != want) begin fails++; $display("FAIL starve_order[%0d]: got %c required %c", k, ev[k], want); end
    end
    repeat (3) @(posedge sram_clk);
    #1;
  endtask

  task automatic test_starvation_limit1();
    byte ev [$];
    wrAddrB = 18'h10; wrDataB = 32'h11112222; rdAddrB = 18'h11;
    wrReqB = 1'b1; rdReqB = 1'b1;
    for (int c = 0; c < 200 && ev.size() < 8; c++) begin
      @(negedge sram_clk);
      if (wrAckB) ev.push_back("W");
      if (rdValidB) ev.push_back("R");
      @(posedge sram_clk); #1;
      if (wrAckB) wrDataB = $urandom;
    end
    wrReqB = 1'b0; rdReqB = 1'b0;
    checks++; if (ev.size() != 8) begin fails++; $display("FAIL alt_events: got %0d events required 8", ev.size()); end
    for (int k = 0; k < ev.size(); k++) begin
      byte want = (k % 2 == 1) ? "R" : "W";
      checks++; if (ev[k] != want) begin fails++; $display("FAIL alt_order[%0d]: got %c required %c", k, ev[k], want); end
    end
  endtask

  task automatic test_reset_mid_write();
    int acks = 0, cyc;
    logic [31:0] got;
    int vc;
    logic [31:0] d2 = $urandom | 32'h00010001;
    wrAddr = 18'h30; wrData = 32'h5EED5EED; wrReq = 1'b1;
    // cycle 0 is the grant IDLE; cycle 3 is the second WE-low cycle
    for (int c = 0; c < 3; c++) begin
      @(posedge sram_clk); #1;
    end
    @(negedge sram_clk);
    checks++; if (srWeN !== 1'b0) begin fails++; $display("FAIL rst_precond_we: got %b required 0", srWeN); end
    #2;
    sram_reset_n = 1'b0;
    wrReq = 1'b0;
    #1;
    checks++; if ({srOeN, srWeN, srCe1N, srCe2N} !== 4'b1111) begin fails++; $display("FAIL rst_mid_strobes: got %b required 1111", {srOeN, srWeN, srCe1N, srCe2N}); end
    checks++; if (!(released(srData1) && released(srData2))) begin fails++; $display("FAIL rst_mid_bus: got %h_%h required released", srData2, srData1); end
    checks++; if (busy !== 1'b0 || wrAck !== 1'b0) begin fails++; $display("FAIL rst_mid_busy_ack: got busy %b ack %b required 0 0", busy, wrAck); end
    @(posedge sram_clk); #1;
    sram_reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge sram_clk);
      if (wrAck) acks++;
    end
    @(posedge sram_clk); #1;
    checks++; if (acks != 0) begin fails++; $display("FAIL rst_dropped_ack: got %0d acks required 0", acks); end
    doWrite(18'h30, d2, cyc);
    doRead(18'h30, got, vc);
    checks++; if (got !== d2) begin fails++; $display("FAIL rst_reissue_data: got %h required %h", got, d2); end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [31:0] got;
    doWrite(18'h80, 32'h0F0F1E1E, c1);
    doWrite(18'h81, 32'h2D2D3C3C, c2);
    checks++; if (c2 - c1 != WE + 3) begin fails++; $display("FAIL b2b_write_spacing: got %0d required %0d", c2 - c1, WE + 3); end
    doRead(18'h80, got, c1);
    doRead(18'h81, got, c2);
    checks++; if (c2 - c1 != RD + 2) begin fails++; $display("FAIL b2b_read_spacing: got %0d required %0d", c2 - c1, RD + 2); end
    checks++; if (got !== 32'h2D2D3C3C) begin fails++; $display("FAIL b2b_read_data: got %h required 2d2d3c3c", got); end
    for (int n = 0; n < 30; n++) begin
      logic [17:0] a = 18'h100 + 18'($urandom_range(0, 7));
      if ((n % 2 == 0) || $urandom_range(0, 3) == 0) begin
        doWrite(a, $urandom | 32'h00010001, c1);
      end else begin
        logic [31:0] want = expectRead(a);
        doRead(a, got, c1);
        checks++; if (got !== want) begin fails++; $display("FAIL rand_read[%0d]: addr %h got %h required %h", n, a, got, want); end
      end
      repeat ($urandom_range(0, 2)) @(posedge sram_clk);
      #1;
    end
    repeat (2) @(posedge sram_clk);
    checks++; if (violations != 0) begin fails++; $display("FAIL bus_rules: got %0d violating cycles required 0", violations); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_starvation_limit1();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
